// File: rtl/core_pipe_exec_mdu.sv
// Iterative RV64M multiply/divide unit: shift-add multiplier (MUL_UNROLL bits/cycle), restoring divider (1 bit/cycle).
// Optional MDU_EARLY_OUT_EN: zero multiply operand, divide by zero and MIN/-1 go IDLE -> DONE directly.
module core_pipe_exec_mdu #(
   parameter int XLEN       = 64,
   parameter int MUL_UNROLL = 1
) (
   input  logic            g_clk,
   input  logic            g_reset,
   input  logic            valid,
   input  logic            new_instr,
   input  logic            op_mul,
   input  logic            op_mulh,
   input  logic            op_mulhsu,
   input  logic            op_mulhu,
   input  logic            op_div,
   input  logic            op_divu,
   input  logic            op_rem,
   input  logic            op_remu,
   input  logic            op_word,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   output logic            ready,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      logic [XLEN-1:0] r;
      r       = {XLEN{v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   logic [1:0]      r_state;
   logic [CW-1:0]   r_cnt;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_result;
   logic            r_word;
   logic            r_mulhi;
   logic            r_rem;
   logic            r_negp;
   logic            r_negr;

   logic            w_word;
   logic            w_is_mul;
   logic            w_is_div;
   logic            w_s1;
   logic            w_s2;
   logic            w_n1;
   logic            w_n2;
   logic            w_start;
   logic [CW-1:0]   w_cnt0;
   logic [XLEN-1:0] w_x1;
   logic [XLEN-1:0] w_x2;
   logic [XLEN-1:0] w_a;
   logic [XLEN-1:0] w_b;
   logic [XLEN-1:0] w_dvd;

   assign w_word   = (XLEN == 64) && op_word;
   assign w_is_mul = op_mul | op_mulh | op_mulhsu | op_mulhu;
   assign w_is_div = op_div | op_divu | op_rem | op_remu;
   assign w_s1     = op_mulh | op_mulhsu | op_div | op_rem;
   assign w_s2     = op_mulh | op_div | op_rem;
   assign w_start  = valid && !new_instr && (w_is_mul || w_is_div);
   assign w_cnt0   = w_word ? CW'(32) : CW'(XLEN);

   // Word operands are widened first so the magnitude of -2^31 still fits.
   assign w_x1  = w_word ? (w_s1 ? sext32(rs1[31:0]) : XLEN'(rs1[31:0])) : rs1;
   assign w_x2  = w_word ? (w_s2 ? sext32(rs2[31:0]) : XLEN'(rs2[31:0])) : rs2;
   assign w_n1  = w_s1 && w_x1[XLEN-1];
   assign w_n2  = w_s2 && w_x2[XLEN-1];
   assign w_a   = w_n1 ? -w_x1 : w_x1;
   assign w_b   = w_n2 ? -w_x2 : w_x2;
   assign w_dvd = w_word ? (w_a << (XLEN - 32)) : w_a;

   logic [XLEN-1:0]   w_mhi;
   logic [XLEN-1:0]   w_mlo;
   logic [XLEN:0]     w_msum;
   logic [2*XLEN-1:0] w_prod;
   logic [2*XLEN-1:0] w_pfix;
   logic [XLEN-1:0]   w_mul_res;

   always_comb begin
      w_mhi  = r_hi;
      w_mlo  = r_lo;
      w_msum = '0;
      for (int i = 0; i < MUL_UNROLL; i++) begin
         w_msum = {1'b0, w_mhi} + (w_mlo[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
         w_mhi  = w_msum[XLEN:1];
         w_mlo  = {w_msum[0], w_mlo[XLEN-1:1]};
      end
   end

   // After W steps of a word multiply the low product word sits at the top of the low half.
   assign w_prod    = {w_mhi, w_mlo};
   assign w_pfix    = r_negp ? -w_prod : w_prod;
   assign w_mul_res = r_mulhi ? w_pfix[2*XLEN-1:XLEN]
                    : (r_word ? sext32(w_pfix[XLEN-1 -: 32]) : w_pfix[XLEN-1:0]);

   logic [XLEN:0]   w_dsh;
   logic [XLEN:0]   w_ddiff;
   logic            w_dge;
   logic [XLEN-1:0] w_drem;
   logic [XLEN-1:0] w_dquo;
   logic [XLEN-1:0] w_dq;
   logic [XLEN-1:0] w_dr;
   logic [XLEN-1:0] w_dval;
   logic [XLEN-1:0] w_div_res;

   assign w_dsh     = {r_hi, r_lo[XLEN-1]};
   assign w_ddiff   = w_dsh - {1'b0, r_a};
   assign w_dge     = ~w_ddiff[XLEN];
   assign w_drem    = w_dge ? w_ddiff[XLEN-1:0] : w_dsh[XLEN-1:0];
   assign w_dquo    = {r_lo[XLEN-2:0], w_dge};
   assign w_dq      = r_negp ? -w_dquo : w_dquo;
   assign w_dr      = r_negr ? -w_drem : w_drem;
   assign w_dval    = r_rem ? w_dr : w_dq;
   assign w_div_res = r_word ? sext32(w_dval[31:0]) : w_dval;

`ifdef MDU_EARLY_OUT_EN
   logic [XLEN-1:0] w_min;
   logic [XLEN-1:0] w_r1;
   logic            w_ovf;
   logic            w_early;
   logic [XLEN-1:0] w_early_res;

   assign w_min   = w_word ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
   assign w_r1    = w_word ? sext32(rs1[31:0]) : rs1;
   assign w_ovf   = (op_div | op_rem) && (w_x1 == w_min) && (w_x2 == {XLEN{1'b1}});
   assign w_early = w_is_mul ? ((w_x1 == '0) || (w_x2 == '0)) : ((w_x2 == '0) || w_ovf);

   always_comb begin
      w_early_res = '0;
      if (w_is_div) begin
         if (w_x2 == '0)
            w_early_res = (op_rem | op_remu) ? w_r1 : {XLEN{1'b1}};
         else
            w_early_res = (op_rem | op_remu) ? '0 : w_min;
      end
   end
`endif

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_a      <= '0;
         r_result <= '0;
         r_word   <= 1'b0;
         r_mulhi  <= 1'b0;
         r_rem    <= 1'b0;
         r_negp   <= 1'b0;
         r_negr   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_word  <= w_word;
                  r_mulhi <= op_mulh | op_mulhsu | op_mulhu;
                  r_rem   <= op_rem | op_remu;
                  r_negr  <= w_n1;
                  r_cnt   <= w_cnt0;
                  r_hi    <= '0;
                  if (w_is_mul) begin
                     r_a     <= w_a;
                     r_lo    <= w_b;
                     r_negp  <= w_n1 ^ w_n2;
                     r_state <= S_MUL;
                  end else begin
                     // A zero divisor keeps the all-ones quotient unsigned.
                     r_a     <= w_b;
                     r_lo    <= w_dvd;
                     r_negp  <= (w_n1 ^ w_n2) && (w_b != '0);
                     r_state <= S_DIV;
                  end
`ifdef MDU_EARLY_OUT_EN
                  if (w_early) begin
                     r_state  <= S_DONE;
                     r_result <= w_early_res;
                  end
`endif
               end
            end
            S_MUL: begin
               if (!valid) begin
                  r_state <= S_IDLE;
               end else begin
                  r_hi  <= w_mhi;
                  r_lo  <= w_mlo;
                  r_cnt <= r_cnt - CW'(MUL_UNROLL);
                  if (r_cnt == CW'(MUL_UNROLL)) begin
                     r_state  <= S_DONE;
                     r_result <= w_mul_res;
                  end
               end
            end
            S_DIV: begin
               if (!valid) begin
                  r_state <= S_IDLE;
               end else begin
                  r_hi  <= w_drem;
                  r_lo  <= w_dquo;
                  r_cnt <= r_cnt - CW'(1);
                  if (r_cnt == CW'(1)) begin
                     r_state  <= S_DONE;
                     r_result <= w_div_res;
                  end
               end
            end
            S_DONE: begin
               if (!valid || new_instr)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ready  = (r_state == S_DONE);
   assign result = r_result;

endmodule
